z80_block_xfer: RTL and testbench
=================================

// Module: z80_block_xfer
// PURPOSE
//  Sequential block-transfer engine for the Z80 core: executes LDI/LDD/LDIR/LDDR
//  as a multi-cycle FSM over a req/ack memory port. Copies byte (HL)->(DE), steps
//  HL/DE by +-1, decrements BC, repeats until BC==0 in repeat mode. Sits beside
//  the ED-prefix decoder; the decoder supplies register values and consumes results.
// PARAMETERS
//  ADDR_WIDTH  16  width of HL/DE pointers and memory addresses
//  CNT_WIDTH   16  width of BC byte counter
// PORTS
//  clk          in   1           core clock; all state on rising edge
//  reset        in   1           asynchronous, active-high reset
//  start        in   1           launch transfer; sampled only in IDLE
//  mode         in   2           [0]=dir (0 inc LDI, 1 dec LDD), [1]=repeat (LDxR)
//  hl_in/de_in  in   ADDR_WIDTH  source/destination pointers, captured on start
//  bc_in        in   CNT_WIDTH   byte count, captured on start
//  f_in         in   8           flags, captured on start
//  busy         out  1           high from cycle after start until done
//  done         out  1           one-cycle pulse at completion
//  hl_out/de_out out ADDR_WIDTH  updated pointers
//  bc_out       out  CNT_WIDTH   updated count
//  f_out        out  8           updated flags
//  mem_rd_req   out  1           read request, held until mem_rd_ack
//  mem_raddr    out  ADDR_WIDTH  read address (=HL)
//  mem_rd_ack   in   1           read complete; mem_rdata valid this cycle
//  mem_rdata    in   8           read data
//  mem_wr_req   out  1           write request, held until mem_wr_ack
//  mem_waddr    out  ADDR_WIDTH  write address (=DE)
//  mem_wdata    out  8           write data (byte captured from read)
//  mem_wr_ack   in   1           write accepted
// BEHAVIOUR
//  - Reset: all outputs 0, FSM->IDLE; asserted mid-transfer abandons it at once
//    (reqs drop asynchronously, no further writes, no done).
//  - States: IDLE -> RD -> WR -> STEP -> (RD | FIN) ; FIN -> IDLE.
//  - IDLE: start=1 captures inputs, -> RD. start ignored in every other state.
//  - RD: mem_rd_req=1, raddr=HL; ack in same cycle allowed; on ack latch rdata, -> WR.
//  - WR: mem_wr_req=1, waddr=DE, wdata=latched byte; on ack -> STEP.
//  - STEP (1 cycle): HL,DE +=1 (dir=0) or -=1 (dir=1), mod 2^ADDR_WIDTH;
//    BC -= 1 mod 2^CNT_WIDTH; F: H(bit4)=0, N(bit1)=0, PV(bit2)=(BC_new!=0),
//    other bits preserved from f_in. Next: repeat && BC_new!=0 -> RD, else FIN.
//  - FIN: done=1, busy=0 for one cycle; outputs hold until next start.
//  - Min latency, zero-wait acks: 3 cycles per byte + 1 FIN cycle.
//  - bc_in=0 with repeat: counter wraps, 2^CNT_WIDTH bytes moved (Z80 behaviour).
//  - Pointer wrap: HL=0 dir=1 -> 2^ADDR_WIDTH-1; HL=max dir=0 -> 0.
//  - Overlapping source/destination: no special handling; strict byte order.
//  - rd_req and wr_req never high simultaneously.
// CONFIGURATION
//  Z80_BLOCK_XFER_ABORT_EN defined: adds input abort (1 bit) and output
//   rewind (1 bit). abort high during STEP of a repeat transfer with BC_new!=0
//   -> FIN instead of RD, rewind=1 with done (caller re-fetches the LDxR, as on
//   an interrupt); flags/regs reflect the completed byte. Otherwise rewind=0.
//  Undefined: no ports; repeat runs to BC==0 uninterruptibly.
// TESTING
//  1 LDI: HL=1000 DE=2000 BC=0003 F=FF, mem[1000]=5A, zero-wait -> mem[2000]=5A,
//    HL=1001 DE=2001 BC=0002 F=ED, done 4 cycles after RD entry.
//  2 LDD with BC=0001, F=00 -> HL/DE decremented, BC=0000, F=00 (PV=0).
//  3 LDIR BC=0004 src 10..13 -> 4 bytes copied in order, BC=0, PV=0, one done.
//  4 Wait states: ack delayed 3 cycles on each port -> reqs/addrs held stable,
//    single write per byte, result identical to test 1.
//  5 LDDR HL=0000 DE=0001 BC=0002 -> HL wraps to FFFE, DE=FFFF; reset asserted
//    during second WR -> wr_req drops immediately, outputs 0, no done.
//  6 (ABORT_EN) LDIR BC=0005, abort at STEP of byte 2 -> done, rewind=1,
//    BC=0003, PV=1; start pulsed while busy earlier -> ignored.

Source files
------------

// File: rtl/z80_block_xfer.sv
// z80_block_xfer: LDI/LDD/LDIR/LDDR block-transfer engine over a req/ack memory port.
// Build option Z80_BLOCK_XFER_ABORT_EN adds abort/rewind for interrupting LDxR.
module z80_block_xfer #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] hl_in,
  input  logic [ADDR_WIDTH-1:0] de_in,
  input  logic [CNT_WIDTH-1:0]  bc_in,
  input  logic [7:0]            f_in,
`ifdef Z80_BLOCK_XFER_ABORT_EN
  input  logic                  abort,
  output logic                  rewind,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] hl_out,
  output logic [ADDR_WIDTH-1:0] de_out,
  output logic [CNT_WIDTH-1:0]  bc_out,
  output logic [7:0]            f_out,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rd_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_wr_ack
);

  // state  | meaning
  // IDLE   | waiting for start; outputs hold last result
  // RD     | read (HL) until ack, latch byte
  // WR     | write latched byte to (DE) until ack
  // STEP   | step HL/DE, decrement BC, update flags, choose repeat or finish
  // FIN    | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_STEP, S_FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] hl, de, hl_step, de_step;
  logic [CNT_WIDTH-1:0]  bc, bc_step;
  logic [7:0]            f, f_step, data_q;
  logic                  dir, rpt, more, stop_early;

`ifdef Z80_BLOCK_XFER_ABORT_EN
  logic rewind_q;
  assign stop_early = abort;
  assign rewind     = rewind_q;
`else
  assign stop_early = 1'b0;
`endif

  assign hl_step = dir ? hl - ADDR_ONE : hl + ADDR_ONE;
  assign de_step = dir ? de - ADDR_ONE : de + ADDR_ONE;
  assign bc_step = bc - CNT_ONE;
  assign more    = (bc_step != '0);
  // H and N cleared, PV reports a nonzero remaining count, other bits untouched
  assign f_step  = (f & 8'hE9) | {5'b0, more, 2'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    case (state)
      S_IDLE: if (start) state_d = S_RD;
      S_RD: begin
        busy       = 1'b1;
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_d = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        mem_wr_req = 1'b1;
        if (mem_wr_ack) state_d = S_STEP;
      end
      S_STEP: begin
        busy    = 1'b1;
        state_d = (rpt && more && !stop_early) ? S_RD : S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hl     <= '0;
      de     <= '0;
      bc     <= '0;
      f      <= '0;
      data_q <= '0;
      dir    <= 1'b0;
      rpt    <= 1'b0;
`ifdef Z80_BLOCK_XFER_ABORT_EN
      rewind_q <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        hl  <= hl_in;
        de  <= de_in;
        bc  <= bc_in;
        f   <= f_in;
        dir <= mode[0];
        rpt <= mode[1];
`ifdef Z80_BLOCK_XFER_ABORT_EN
        rewind_q <= 1'b0;
`endif
      end
      if (state == S_RD && mem_rd_ack) data_q <= mem_rdata;
      if (state == S_STEP) begin
        hl <= hl_step;
        de <= de_step;
        bc <= bc_step;
        f  <= f_step;
`ifdef Z80_BLOCK_XFER_ABORT_EN
        rewind_q <= rpt && more && abort;
`endif
      end
    end
  end

  assign hl_out    = hl;
  assign de_out    = de;
  assign bc_out    = bc;
  assign f_out     = f;
  assign mem_raddr = hl;
  assign mem_waddr = de;
  assign mem_wdata = data_q;

endmodule

// File: tb/tb_z80_block_xfer.sv
// Self-checking bench for z80_block_xfer with a wait-state memory responder and a
// write scoreboard; covers the Z80_BLOCK_XFER_ABORT_EN build when that macro is set.
module tb_z80_block_xfer;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] hl_in = '0, de_in = '0;
  logic [CW-1:0] bc_in = '0;
  logic [7:0]    f_in = '0;
  logic          busy, done;
  logic [AW-1:0] hl_out, de_out, mem_raddr, mem_waddr;
  logic [CW-1:0] bc_out;
  logic [7:0]    f_out, mem_wdata;
  logic          mem_rd_req, mem_wr_req;
  logic          mem_rd_ack = 1'b0, mem_wr_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
`ifdef Z80_BLOCK_XFER_ABORT_EN
  logic          abort = 1'b0;
  logic          rewind;
`endif

  z80_block_xfer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .hl_in(hl_in), .de_in(de_in), .bc_in(bc_in), .f_in(f_in),
`ifdef Z80_BLOCK_XFER_ABORT_EN
    .abort(abort), .rewind(rewind),
`endif
    .busy(busy), .done(done),
    .hl_out(hl_out), .de_out(de_out), .bc_out(bc_out), .f_out(f_out),
    .mem_rd_req(mem_rd_req), .mem_raddr(mem_raddr), .mem_rd_ack(mem_rd_ack),
    .mem_rdata(mem_rdata),
    .mem_wr_req(mem_wr_req), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  int rd_wait = 0, wr_wait = 0, rd_cnt = 0, wr_cnt = 0;
  bit overlap = 1'b0, unstable = 1'b0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_raddr = '0, prev_waddr = '0;

  // Memory responder: acks after rd_wait/wr_wait idle cycles; accepted writes go to obs_q
  always @(negedge clk) begin
    if (mem_rd_req && mem_wr_req) overlap = 1'b1;
    if (mem_rd_req && prev_rd && mem_raddr != prev_raddr) unstable = 1'b1;
    if (mem_wr_req && prev_wr && mem_waddr != prev_waddr) unstable = 1'b1;
    prev_rd = mem_rd_req; prev_wr = mem_wr_req;
    prev_raddr = mem_raddr; prev_waddr = mem_waddr;
    if (done) done_cnt++;
    if (mem_rd_req) begin
      if (rd_cnt >= rd_wait) begin
        mem_rd_ack = 1'b1; mem_rdata = mem[mem_raddr]; rd_cnt = 0;
      end else begin
        mem_rd_ack = 1'b0; rd_cnt++;
      end
    end else begin
      mem_rd_ack = 1'b0; rd_cnt = 0;
    end
    if (mem_wr_req) begin
      if (wr_cnt >= wr_wait) begin
        mem_wr_ack = 1'b1; wr_cnt = 0;
        mem[mem_waddr] = mem_wdata;
        obs_q.push_back({mem_waddr, mem_wdata});
      end else begin
        mem_wr_ack = 1'b0; wr_cnt++;
      end
    end else begin
      mem_wr_ack = 1'b0; wr_cnt = 0;
    end
  end

  // Reference model: queues expected writes, returns expected final registers
  task automatic model_xfer(input logic [1:0] m, input logic [15:0] h, d, b,
                            input logic [7:0] fl, input int max_bytes,
                            output logic [15:0] eh, ed, eb, output logic [7:0] ef);
    logic [7:0] sh [int];
    logic [7:0] v;
    int n = 0;
    eh = h; ed = d; eb = b; ef = fl;
    do begin
      v = sh.exists(int'(eh)) ? sh[int'(eh)] : mem[eh];
      sh[int'(ed)] = v;
      exp_q.push_back({ed, v});
      eh = m[0] ? eh - 16'd1 : eh + 16'd1;
      ed = m[0] ? ed - 16'd1 : ed + 16'd1;
      eb = eb - 16'd1;
      ef = (ef & 8'hE9) | ((eb != 16'd0) ? 8'h04 : 8'h00);
      n++;
    end while (m[1] && eb != 16'd0 && n < max_bytes);
  endtask

  task automatic start_xfer(input logic [1:0] m, input logic [15:0] h, d, b,
                            input logic [7:0] fl);
    @(negedge clk);
    mode = m; hl_in = h; de_in = d; bc_in = b; f_in = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, mem_rd_req, mem_wr_req} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {busy, done, mem_rd_req, mem_wr_req}); end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out, mem_wdata} !== 64'd0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", {hl_out, de_out, bc_out, f_out, mem_wdata}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi(input string nm, input int rw, input int ww);
    logic [15:0] eh, ed, eb; logic [7:0] ef; int cyc, d0;
    rd_wait = rw; wr_wait = ww; unstable = 1'b0;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    mem[16'h1000] = 8'h5A; mem[16'h2000] = 8'h00;
    model_xfer(2'b00, 16'h1000, 16'h2000, 16'h0003, 8'hFF, 1 << 20, eh, ed, eb, ef);
    start_xfer(2'b00, 16'h1000, 16'h2000, 16'h0003, 8'hFF);
    n_cmp++; if (busy !== 1'b1 || mem_rd_req !== 1'b1 || mem_raddr !== 16'h1000) begin n_bad++; $display("FAIL %s_rd_entry: busy=%b rd_req=%b raddr=%h want 1 1 1000", nm, busy, mem_rd_req, mem_raddr); end
    wait_done(100, cyc);
    // start edge counts as cycle 1: RD, WR, STEP then FIN
    if (rw == 0 && ww == 0) begin
      n_cmp++; if (cyc + 1 !== 4) begin n_bad++; $display("FAIL %s_latency: got %0d want 4", nm, cyc + 1); end
    end else begin
      n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL %s_timeout: got no done want done", nm); end
      n_cmp++; if (unstable !== 1'b0) begin n_bad++; $display("FAIL %s_addr_stable: got %b want 0", nm, unstable); end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s_fin: done=%b busy=%b want 1 0", nm, done, busy); end
`ifdef Z80_BLOCK_XFER_ABORT_EN
    n_cmp++; if (rewind !== 1'b0) begin n_bad++; $display("FAIL %s_rewind: got %b want 0", nm, rewind); end
`endif
    repeat (2) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1 || done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse: got %0d pulses want 1", nm, done_cnt - d0); end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== {eh, ed, eb, ef}) begin n_bad++; $display("FAIL %s_regs: got %h %h %h %h want %h %h %h %h", nm, hl_out, de_out, bc_out, f_out, eh, ed, eb, ef); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL %s_nwrites: got %0d want %0d", nm, obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL %s_write%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out, mem[16'h2000]} !== 64'h1001_2001_0002_ED_5A) begin n_bad++; $display("FAIL %s_const: got %h %h %h %h %h want 1001 2001 0002 ED 5A", nm, hl_out, de_out, bc_out, f_out, mem[16'h2000]); end
    rd_wait = 0; wr_wait = 0;
  endtask

  task automatic test_single(input string nm, input logic [1:0] m, input logic [15:0] h, d, b,
                             input logic [7:0] fl, input logic [7:0] val);
    logic [15:0] eh, ed, eb; logic [7:0] ef; int cyc, d0;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    mem[h] = val;
    model_xfer(m, h, d, b, fl, 1 << 20, eh, ed, eb, ef);
    start_xfer(m, h, d, b, fl);
    wait_done(100, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL %s_timeout: got no done want done", nm); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== {eh, ed, eb, ef}) begin n_bad++; $display("FAIL %s_regs: got %h %h %h %h want %h %h %h %h", nm, hl_out, de_out, bc_out, f_out, eh, ed, eb, ef); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt - d0); end
    n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL %s_write: got %0d writes first %h want 1 write %h", nm, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0, exp_q[0]); end
  endtask

  task automatic test_ldir_ignore_start;
    logic [15:0] eh, ed, eb; logic [7:0] ef; int cyc, d0;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 4; i++) mem[16'h3000 + i] = 8'h10 + 8'(i);
    model_xfer(2'b10, 16'h3000, 16'h4000, 16'h0004, 8'hD7, 1 << 20, eh, ed, eb, ef);
    start_xfer(2'b10, 16'h3000, 16'h4000, 16'h0004, 8'hD7);
    @(negedge clk);
    hl_in = 16'h5555; de_in = 16'h6666; bc_in = 16'h0009; mode = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    wait_done(100, cyc);
    n_cmp++; if (cyc + 2 !== 12) begin n_bad++; $display("FAIL ldir_latency: got %0d want 12", cyc + 2); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== 56'h3004_4004_0000_C1) begin n_bad++; $display("FAIL ldir_regs: got %h %h %h %h want 3004 4004 0000 C1", hl_out, de_out, bc_out, f_out); end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== {eh, ed, eb, ef}) begin n_bad++; $display("FAIL ldir_model: got %h %h %h %h want %h %h %h %h", hl_out, de_out, bc_out, f_out, eh, ed, eb, ef); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ldir_done_cnt: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ldir_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ldir_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lddr_wrap_reset;
    logic [15:0] eh, ed, eb; logic [7:0] ef; int cyc, d0, k;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    mem[16'h0000] = 8'hA1; mem[16'hFFFF] = 8'hB2;
    model_xfer(2'b11, 16'h0000, 16'h0001, 16'h0002, 8'h12, 1 << 20, eh, ed, eb, ef);
    start_xfer(2'b11, 16'h0000, 16'h0001, 16'h0002, 8'h12);
    wait_done(100, cyc);
    repeat (2) @(negedge clk);
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== 56'hFFFE_FFFF_0000_00) begin n_bad++; $display("FAIL lddr_wrap: got %h %h %h %h want FFFE FFFF 0000 00", hl_out, de_out, bc_out, f_out); end
    n_cmp++; if (obs_q.size() !== 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin n_bad++; $display("FAIL lddr_writes: got %0d writes want %h %h", obs_q.size(), exp_q[0], exp_q[1]); end
    // Rerun with write wait states and reset during the second write
    exp_q.delete(); obs_q.delete(); d0 = done_cnt; wr_wait = 3;
    model_xfer(2'b11, 16'h0000, 16'h0001, 16'h0002, 8'h12, 1 << 20, eh, ed, eb, ef);
    start_xfer(2'b11, 16'h0000, 16'h0001, 16'h0002, 8'h12);
    k = 0;
    while (!(mem_wr_req === 1'b1 && bc_out === 16'h0001) && k < 100) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 100) begin n_bad++; $display("FAIL rst_reach_wr2: got timeout want second WR"); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (mem_wr_req !== 1'b0 || mem_rd_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_drop: wr=%b rd=%b busy=%b want 0 0 0", mem_wr_req, mem_rd_req, busy); end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out, mem_wdata} !== 64'd0) begin n_bad++; $display("FAIL rst_regs: got %h want 0", {hl_out, de_out, bc_out, f_out, mem_wdata}); end
    repeat (2) @(negedge clk);
    reset = 1'b0; wr_wait = 0;
    repeat (6) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL rst_writes: got %0d writes want 1 of %h", obs_q.size(), exp_q[0]); end
    n_cmp++; if (busy !== 1'b0 || mem_wr_req !== 1'b0) begin n_bad++; $display("FAIL rst_idle: busy=%b wr=%b want 0 0", busy, mem_wr_req); end
  endtask

`ifdef Z80_BLOCK_XFER_ABORT_EN
  task automatic test_abort;
    logic [15:0] eh, ed, eb; logic [7:0] ef; int cyc, d0, k;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 5; i++) mem[16'h6000 + i] = 8'hC0 + 8'(i);
    model_xfer(2'b10, 16'h6000, 16'h7000, 16'h0005, 8'h00, 2, eh, ed, eb, ef);
    start_xfer(2'b10, 16'h6000, 16'h7000, 16'h0005, 8'h00);
    hl_in = 16'h1111; bc_in = 16'h0001; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (bc_out !== 16'h0004 && k < 50) begin @(negedge clk); k++; end
    while (mem_wr_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (k >= 50 || done !== 1'b1) begin n_bad++; $display("FAIL abort_fin: done=%b k=%0d want done 1", done, k); end
    n_cmp++; if (rewind !== 1'b1) begin n_bad++; $display("FAIL abort_rewind: got %b want 1", rewind); end
    wait_done(100, cyc);
    repeat (2) @(negedge clk);
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== 56'h6002_7002_0003_04) begin n_bad++; $display("FAIL abort_regs: got %h %h %h %h want 6002 7002 0003 04", hl_out, de_out, bc_out, f_out); end
    n_cmp++; if ({hl_out, de_out, bc_out, f_out} !== {eh, ed, eb, ef}) begin n_bad++; $display("FAIL abort_model: got %h %h %h %h want %h %h %h %h", hl_out, de_out, bc_out, f_out, eh, ed, eb, ef); end
    n_cmp++; if (done_cnt - d0 !== 1 || obs_q.size() !== 2) begin n_bad++; $display("FAIL abort_counts: got %0d done %0d writes want 1 2", done_cnt - d0, obs_q.size()); end
    n_cmp++; if (rewind !== 1'b1) begin n_bad++; $display("FAIL abort_rewind_hold: got %b want 1", rewind); end
  endtask
`endif

  initial begin
    test_reset();
    test_ldi("ldi", 0, 0);
    test_single("ldd", 2'b01, 16'h1234, 16'h5678, 16'h0001, 8'h00, 8'h3C);
    test_single("ldi_wrap", 2'b00, 16'hFFFF, 16'h7FFF, 16'h0000, 8'h12, 8'h77);
    test_ldir_ignore_start();
    test_ldi("ldi_wait", 3, 3);
    test_lddr_wrap_reset();
`ifdef Z80_BLOCK_XFER_ABORT_EN
    test_abort();
`endif
    n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL req_overlap: got %b want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
